// File: rtl/uart_pkg.sv
// Shared types and constants for the UART block.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_MIN_BAUD_DIV = 4;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for asynchronous UART inputs; flops reset to the
// idle-high line level so no false edge is seen after reset.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clock_i,
  input  logic resetn_i,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_r;

  // Shift chain, bit 0 faces the pin
  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      sync_r <= {STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
    end
  end

  assign dout = sync_r[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receive engine: start detect, mid-bit sampling against a
// per-frame latched divider, framing-error detection and break handling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int BAUD_DIV_W  = 12
) (
  input  logic                      clock_i,
  input  logic                      resetn_i,
  input  logic [BAUD_DIV_W-1:0]     baud_div,
  input  logic                      rx_din_i,
  output logic [UART_DATA_BITS-1:0] rx_data_o,
  output logic                      rx_done,
  output logic                      rx_ing,
  output logic                      rx_err
);

  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [BAUD_DIV_W-1:0] CNT_ZERO = {BAUD_DIV_W{1'b0}};
  localparam logic [BAUD_DIV_W-1:0] CNT_ONE  = BAUD_DIV_W'(1'b1);
  localparam logic [BAUD_DIV_W-1:0] MIN_DIV  = BAUD_DIV_W'(UART_MIN_BAUD_DIV);
  localparam logic [BIT_W-1:0]      BIT_ZERO = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0]      BIT_ONE  = BIT_W'(1'b1);
  localparam logic [BIT_W-1:0]      BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

  logic                      rxd_sync_s;
  logic                      prev_r;
  uart_rx_state_t            state_r, state_nxt_s;
  logic [BAUD_DIV_W-1:0]     cnt_r, cnt_nxt_s;
  logic [BAUD_DIV_W-1:0]     bdiv_r, bdiv_nxt_s;
  logic [BAUD_DIV_W-1:0]     bdiv_clamp_s, bdiv_m1_s, half_m1_s;
  logic [BIT_W-1:0]          bit_idx_r, bit_idx_nxt_s;
  logic [UART_DATA_BITS-1:0] shift_r, shift_nxt_s;
  logic [UART_DATA_BITS-1:0] rx_data_r, data_nxt_s;
  logic                      rx_done_r, done_nxt_s;
  logic                      rx_err_r, err_nxt_s;
  logic                      rx_ing_r, ing_nxt_s;

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock_i  (clock_i),
    .resetn_i (resetn_i),
    .din      (rx_din_i),
    .dout     (rxd_sync_s)
  );

  assign bdiv_clamp_s = (baud_div < MIN_DIV) ? MIN_DIV : baud_div;
  assign bdiv_m1_s    = bdiv_r - CNT_ONE;
  // Latched divider is at least 4, so half-bit minus one never underflows
  assign half_m1_s    = {1'b0, bdiv_r[BAUD_DIV_W-1:1]} - CNT_ONE;

  // Next-state and datapath update
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r + CNT_ONE;
    bdiv_nxt_s    = bdiv_r;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    data_nxt_s    = rx_data_r;
    done_nxt_s    = 1'b0;
    err_nxt_s     = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_nxt_s     = CNT_ZERO;
        bit_idx_nxt_s = BIT_ZERO;
        if (prev_r && !rxd_sync_s) begin
          state_nxt_s = START;
          bdiv_nxt_s  = bdiv_clamp_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == half_m1_s) begin
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = rxd_sync_s ? IDLE : DATA;
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (cnt_r == bdiv_m1_s) begin
          cnt_nxt_s   = CNT_ZERO;
          shift_nxt_s = {rxd_sync_s, shift_r[UART_DATA_BITS-1:1]};
          if (bit_idx_r == BIT_LAST) begin
            bit_idx_nxt_s = BIT_ZERO;
            state_nxt_s   = STOP;
          end else begin
            bit_idx_nxt_s = bit_idx_r + BIT_ONE;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      STOP: begin
        if (cnt_r == bdiv_m1_s) begin
          cnt_nxt_s  = CNT_ZERO;
          data_nxt_s = shift_r;
          if (rxd_sync_s) begin
            done_nxt_s  = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            err_nxt_s   = 1'b1;
            state_nxt_s = BREAK;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end
      BREAK: begin
        cnt_nxt_s = CNT_ZERO;
        if (rxd_sync_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BREAK;
        end
      end
      default: begin
        cnt_nxt_s   = CNT_ZERO;
        state_nxt_s = IDLE;
      end
    endcase
    ing_nxt_s = (state_nxt_s == START) || (state_nxt_s == DATA) || (state_nxt_s == STOP);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      state_r   <= IDLE;
      prev_r    <= 1'b1;
      cnt_r     <= CNT_ZERO;
      bdiv_r    <= MIN_DIV;
      bit_idx_r <= BIT_ZERO;
      shift_r   <= {UART_DATA_BITS{1'b0}};
      rx_data_r <= {UART_DATA_BITS{1'b0}};
      rx_done_r <= 1'b0;
      rx_err_r  <= 1'b0;
      rx_ing_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      prev_r    <= rxd_sync_s;
      cnt_r     <= cnt_nxt_s;
      bdiv_r    <= bdiv_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shift_r   <= shift_nxt_s;
      rx_data_r <= data_nxt_s;
      rx_done_r <= done_nxt_s;
      rx_err_r  <= err_nxt_s;
      rx_ing_r  <= ing_nxt_s;
    end
  end

  assign rx_data_o = rx_data_r;
  assign rx_done   = rx_done_r;
  assign rx_err    = rx_err_r;
  assign rx_ing    = rx_ing_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed, table-driven bench for uart_rx with hand-computed frame timing.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        resetn;
  logic [11:0] baud_div;
  logic        rx_din;
  logic [7:0]  rx_data;
  logic        rx_done, rx_ing, rx_err;

  uart_rx #(
    .SYNC_STAGES (2),
    .BAUD_DIV_W  (12)
  ) dut (
    .clock_i   (clk),
    .resetn_i  (resetn),
    .baud_div  (baud_div),
    .rx_din_i  (rx_din),
    .rx_data_o (rx_data),
    .rx_done   (rx_done),
    .rx_ing    (rx_ing),
    .rx_err    (rx_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, rise_cnt = 0;
  int last_done_cyc = 0, prev_done_cyc = 0, last_err_cyc = 0;
  int rise_cyc = 0, fall_cyc = 0;
  logic [7:0] last_done_data = 8'h00, prev_done_data = 8'h00;
  logic ing_q = 1'b0;

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      prev_done_cyc  = last_done_cyc;
      prev_done_data = last_done_data;
      last_done_cyc  = cyc;
      last_done_data = rx_data;
    end
    if (rx_err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (rx_done && rx_err) both_cnt++;
    if (rx_ing && !ing_q) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    if (!rx_ing && ing_q) fall_cyc = cyc;
    ing_q = rx_ing;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drive the pin just after a rising edge and hold for n cycles
  task automatic hold(input logic v, input int n);
    rx_din = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int cpb, input logic stop,
                            input int chg, output int t0);
    t0 = cyc + 2;
    hold(1'b0, cpb);
    for (int i = 0; i < 8; i++) begin
      if (i == 3 && chg != 0) baud_div = 12'(chg);
      hold(d[i], cpb);
    end
    hold(stop, cpb);
  endtask

  typedef struct {
    logic [7:0] data;
    int         div;
    int         cpb;
    logic       stop;
    int         chg;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_data;
    int         exp_lat;
  } vec_t;

  vec_t vecs[6];
  int t0, t1, d0, e0, r0;
  logic [7:0] data_before;

  initial begin
    // latency = H + 9*B + 1 with B = max(div, 4), H = B/2
    vecs[0] = '{8'hA5, 16, 16, 1'b1, 0,  1, 0, 8'hA5, 153};
    vecs[1] = '{8'h3C, 16, 16, 1'b0, 0,  0, 1, 8'h3C, 153};
    vecs[2] = '{8'h5A, 16, 16, 1'b1, 32, 1, 0, 8'h5A, 153};
    vecs[3] = '{8'h81, 2,  4,  1'b1, 0,  1, 0, 8'h81, 39};
    vecs[4] = '{8'hC3, 5,  5,  1'b1, 0,  1, 0, 8'hC3, 48};
    vecs[5] = '{8'h0F, 3,  4,  1'b1, 0,  1, 0, 8'h0F, 39};

    resetn   = 1'b0;
    rx_din   = 1'b1;
    baud_div = 12'd16;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data", int'(rx_data), 0);
    check("reset_done", int'(rx_done), 0);
    check("reset_ing",  int'(rx_ing),  0);
    check("reset_err",  int'(rx_err),  0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    hold(1'b1, 10);

    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt; e0 = err_cnt; r0 = rise_cnt;
      baud_div = 12'(vecs[i].div);
      send_frame(vecs[i].data, vecs[i].cpb, vecs[i].stop, vecs[i].chg, t0);
      if (!vecs[i].stop) hold(1'b0, 40);
      hold(1'b1, 3 * vecs[i].cpb);
      check($sformatf("v%0d_done_cnt", i), done_cnt - d0, vecs[i].exp_done);
      check($sformatf("v%0d_err_cnt", i),  err_cnt - e0,  vecs[i].exp_err);
      check($sformatf("v%0d_data", i),     int'(rx_data), int'(vecs[i].exp_data));
      check($sformatf("v%0d_pulse_lat", i),
            (vecs[i].exp_done != 0 ? last_done_cyc : last_err_cyc) - t0, vecs[i].exp_lat);
      check($sformatf("v%0d_ing_rise", i), rise_cyc - t0, 1);
      check($sformatf("v%0d_ing_fall", i), fall_cyc - t0, vecs[i].exp_lat);
      check($sformatf("v%0d_frames", i),   rise_cnt - r0, 1);
    end

    // False start: 3-cycle low pulse
    baud_div = 12'd16;
    d0 = done_cnt; e0 = err_cnt;
    data_before = rx_data;
    t0 = cyc + 2;
    hold(1'b0, 3);
    hold(1'b1, 40);
    check("fs_ing_rise", rise_cyc - t0, 1);
    check("fs_ing_len",  fall_cyc - rise_cyc, 8);
    check("fs_no_done",  done_cnt - d0, 0);
    check("fs_no_err",   err_cnt - e0, 0);
    check("fs_data",     int'(rx_data), int'(data_before));

    // Back-to-back frames without idle gap
    baud_div = 12'd10;
    d0 = done_cnt;
    send_frame(8'h00, 10, 1'b1, 0, t0);
    send_frame(8'hFF, 10, 1'b1, 0, t1);
    hold(1'b1, 30);
    check("b2b_done_cnt", done_cnt - d0, 2);
    check("b2b_first_lat", prev_done_cyc - t0, 96);
    check("b2b_spacing", last_done_cyc - prev_done_cyc, 100);
    check("b2b_data0", int'(prev_done_data), 8'h00);
    check("b2b_data1", int'(last_done_data), 8'hFF);

    // Reset in the middle of a 0x7E frame
    baud_div = 12'd16;
    d0 = done_cnt; e0 = err_cnt;
    hold(1'b0, 16);
    hold(1'b0, 16);
    hold(1'b1, 8);
    check("rst_pre_ing", int'(rx_ing), 1);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check("rst_data", int'(rx_data), 0);
    check("rst_done", int'(rx_done), 0);
    check("rst_ing",  int'(rx_ing),  0);
    check("rst_err",  int'(rx_err),  0);
    @(posedge clk);
    #1;
    hold(1'b1, 100);
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_no_err",  err_cnt - e0, 0);
    send_frame(8'h7E, 16, 1'b1, 0, t0);
    hold(1'b1, 20);
    check("post_rst_done", done_cnt - d0, 1);
    check("post_rst_lat",  last_done_cyc - t0, 153);
    check("post_rst_data", int'(rx_data), 8'h7E);

    check("done_err_overlap", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
